// File: rtl/cu_pkg.sv
// Shared types and constants for the instruction sequencer: FSM state
// encoding, opcode map and default widths.
package cu_pkg;

   localparam int ADDR_W_DEFAULT  = 8;
   localparam int INSTR_W_DEFAULT = 12;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_DECODE  = 2'd1,
      ST_EXECUTE = 2'd2,
      ST_HALT    = 2'd3
   } state_t;

   localparam logic [3:0] ALU_OP_MAX = 4'hB;
   localparam logic [3:0] OP_JMP     = 4'hC;
   localparam logic [3:0] OP_JZ      = 4'hD;
   localparam logic [3:0] OP_NOP     = 4'hE;
   localparam logic [3:0] OP_HLT     = 4'hF;

   function automatic logic is_alu_op(input logic [3:0] op);
      return op <= ALU_OP_MAX;
   endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register; a jump load takes priority over the sequential
// increment, which wraps modulo 2^ADDR_W.
module program_counter
   import cu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   output logic [ADDR_W-1:0] pc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= '0;
      end else if (load) begin
         pc <= load_val;
      end else if (inc) begin
         pc <= pc + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/control_unit.sv
// Three-cycle fetch/decode/execute sequencer driving an external ALU block.
// Optional macro STEP_EN adds a step input that gates each FETCH.
//
// state   | meaning
// FETCH   | present PC to the ROM (waits for step when STEP_EN)
// DECODE  | ROM word valid, latch into IR
// EXECUTE | strobe ALU or resolve jump/branch, update PC
// HALT    | parked after HLT until reset
module control_unit
   import cu_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEFAULT,
   parameter int INSTR_W = INSTR_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
`ifdef STEP_EN
   input  logic               step,
`endif
   output logic [ADDR_W-1:0]  instr_addr,
   input  logic [INSTR_W-1:0] instr_data,
   input  logic [7:0]         acc_in,
   output logic [3:0]         operation_code,
   output logic               aku_enable,
   output logic [7:0]         in_b,
   output logic               halted
);

   state_t              state, state_nxt;
   logic [INSTR_W-1:0]  ir;
   logic                ir_load;
   logic                pc_inc, pc_load;
   logic [ADDR_W-1:0]   pc;
   logic [ADDR_W-1:0]   jmp_target;
   logic [3:0]          opcode;
   logic                fetch_go;

   assign opcode         = ir[INSTR_W-1 -: 4];
   assign operation_code = opcode;
   assign in_b           = ir[7:0];
   assign jmp_target     = ADDR_W'(ir[7:0]);
   assign instr_addr     = pc;
   assign halted         = (state == ST_HALT);

`ifdef STEP_EN
   assign fetch_go = step;
`else
   assign fetch_go = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir <= '0;
      end else if (ir_load) begin
         ir <= instr_data;
      end
   end

   always_comb begin
      state_nxt  = state;
      ir_load    = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      aku_enable = 1'b0;
      case (state)
         ST_FETCH: begin
            if (fetch_go) begin
               state_nxt = ST_DECODE;
            end
         end
         ST_DECODE: begin
            ir_load   = 1'b1;
            state_nxt = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            state_nxt = ST_FETCH;
            if (is_alu_op(opcode)) begin
               aku_enable = 1'b1;
               pc_inc     = 1'b1;
            end else begin
               case (opcode)
                  OP_JMP: pc_load = 1'b1;
                  OP_JZ: begin
                     // acc_in is the live ALU result from the previous op
                     if (acc_in == 8'd0) begin
                        pc_load = 1'b1;
                     end else begin
                        pc_inc = 1'b1;
                     end
                  end
                  OP_NOP: pc_inc = 1'b1;
                  default: state_nxt = ST_HALT;
               endcase
            end
         end
         default: state_nxt = ST_HALT;
      endcase
   end

   program_counter #(
      .ADDR_W (ADDR_W)
   ) u_pc (
      .clk      (clk),
      .rst      (rst),
      .inc      (pc_inc),
      .load     (pc_load),
      .load_val (jmp_target),
      .pc       (pc)
   );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: instruction-level reference model
// compared every cycle, directed literal checks, randomized programs.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  instr_addr;
   logic [11:0] instr_data;
   logic [7:0]  acc_in = 8'h00;
   logic [3:0]  operation_code;
   logic        aku_enable;
   logic [7:0]  in_b;
   logic        halted;
`ifdef STEP_EN
   logic        step = 1'b1;
`endif

   logic [11:0] rom [256];

   int checks = 0;
   int errors = 0;

   // reference model: program counter, current instruction, cycle within
   // the 3-cycle instruction slot, halt flag
   logic [7:0]  m_pc;
   logic [11:0] m_ir;
   int          m_slot;
   bit          m_halt;
   bit          acc_rand = 1'b1;
   logic [7:0]  acc_fix  = 8'h00;

   control_unit dut (
      .clk            (clk),
      .rst            (rst),
`ifdef STEP_EN
      .step           (step),
`endif
      .instr_addr     (instr_addr),
      .instr_data     (instr_data),
      .acc_in         (acc_in),
      .operation_code (operation_code),
      .aku_enable     (aku_enable),
      .in_b           (in_b),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) instr_data <= rom[instr_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_advance();
      logic [3:0] op;
      logic [7:0] imm;
      if (m_halt) return;
      if (m_slot == 0) begin
`ifdef STEP_EN
         if (step) m_slot = 1;
`else
         m_slot = 1;
`endif
      end else if (m_slot == 1) begin
         m_ir   = rom[m_pc];
         m_slot = 2;
      end else begin
         op  = m_ir[11:8];
         imm = m_ir[7:0];
         m_slot = 0;
         if (op <= 4'hB || op == 4'hE) m_pc = m_pc + 8'd1;
         else if (op == 4'hC)          m_pc = imm;
         else if (op == 4'hD)          m_pc = (acc_in == 8'd0) ? imm : m_pc + 8'd1;
         else                          m_halt = 1'b1;
      end
   endtask

   // compare process: drive acc_in, check DUT against the model, advance model
   always @(negedge clk) begin
      if (acc_rand) acc_in = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      else          acc_in = acc_fix;
      if (rst) begin
         m_pc = 8'h00; m_ir = 12'h000; m_slot = 0; m_halt = 1'b0;
      end
      chk("model_addr", instr_addr, m_pc);
      chk("model_op", operation_code, m_ir[11:8]);
      chk("model_in_b", in_b, m_ir[7:0]);
      chk("model_aku", aku_enable, (!m_halt && m_slot == 2 && m_ir[11:8] <= 4'hB));
      chk("model_halted", halted, m_halt);
      if (!rst) model_advance();
   end

   task automatic rst_on();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_addr", instr_addr, 8'h00);
      chk("rst_halted", halted, 1'b0);
      chk("rst_aku", aku_enable, 1'b0);
      chk("rst_op", operation_code, 4'h0);
   endtask

   task automatic rst_off();
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic fill_rom(input logic [11:0] w);
      for (int i = 0; i < 256; i++) rom[i] = w;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   int aku_cnt;

   initial begin
      fill_rom(12'hE00);

      // ALU op, first instruction after reset
      rst_on(); fill_rom(12'hE00); rom[0] = 12'h105; rst_off();
      cycles(1); chk("alu_c1_addr", instr_addr, 8'h00);
      cycles(1); chk("alu_c2_aku", aku_enable, 1'b0);
      cycles(1);
      chk("alu_op", operation_code, 4'h1);
      chk("alu_in_b", in_b, 8'h05);
      chk("alu_aku", aku_enable, 1'b1);
      cycles(1);
      chk("alu_aku_after", aku_enable, 1'b0);
      chk("alu_next_addr", instr_addr, 8'h01);

      // JMP
      rst_on(); fill_rom(12'hE00); rom[0] = 12'hC40; rst_off();
      cycles(3); chk("jmp_aku", aku_enable, 1'b0);
      cycles(1); chk("jmp_addr", instr_addr, 8'h40);

      // JZ taken / not taken
      rst_on(); fill_rom(12'hE00); rom[0] = 12'hD20; acc_rand = 1'b0; acc_fix = 8'h00; rst_off();
      cycles(3); chk("jz_aku", aku_enable, 1'b0);
      cycles(1); chk("jz_taken_addr", instr_addr, 8'h20);
      rst_on(); acc_fix = 8'h01; rst_off();
      cycles(4); chk("jz_not_taken_addr", instr_addr, 8'h01);
      acc_rand = 1'b1;

      // PC wrap via JMP 0xFF then NOP
      rst_on(); fill_rom(12'hE00); rom[0] = 12'hCFF; rst_off();
      cycles(4); chk("wrap_jmp_addr", instr_addr, 8'hFF);
      cycles(4); chk("wrap_addr", instr_addr, 8'h00);

      // HLT at address 3
      rst_on(); fill_rom(12'hE00); rom[3] = 12'hF00; rst_off();
      cycles(12); chk("hlt_exec_halted", halted, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cycles(1);
         chk("hlt_halted", halted, 1'b1);
         chk("hlt_addr", instr_addr, 8'h03);
         chk("hlt_aku", aku_enable, 1'b0);
      end
      rst_on(); rst_off();
      cycles(1);
      chk("hlt_rst_addr", instr_addr, 8'h00);
      chk("hlt_rst_halted", halted, 1'b0);

      // reset during EXECUTE kills the strobe and the PC update
      rst_on(); fill_rom(12'h105); rst_off();
      cycles(3); chk("midrst_aku_before", aku_enable, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_aku", aku_enable, 1'b0);
      chk("midrst_addr", instr_addr, 8'h00);
      @(posedge clk); @(posedge clk);
      #2 rst = 1'b0;
      cycles(1); chk("midrst_pc_kept", instr_addr, 8'h00);
      cycles(3); chk("midrst_next_addr", instr_addr, 8'h01);

`ifdef STEP_EN
      // single-step: no progress without step, exactly one instruction per pulse
      rst_on(); fill_rom(12'h105); step = 1'b0; rst_off();
      aku_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         cycles(1);
         if (aku_enable === 1'b1) aku_cnt++;
      end
      chk("step_idle_aku", aku_cnt, 0);
      chk("step_idle_addr", instr_addr, 8'h00);
      @(posedge clk); #2 step = 1'b1;
      @(posedge clk); #2 step = 1'b0;
      aku_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         cycles(1);
         if (aku_enable === 1'b1) aku_cnt++;
      end
      chk("step_one_aku", aku_cnt, 1);
      chk("step_one_addr", instr_addr, 8'h01);
      step = 1'b1;
`endif

      // randomized programs, compared against the model every cycle
      for (int it = 0; it < 25; it++) begin
         int n;
         rst_on();
         for (int a = 0; a < 256; a++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            rom[a] = {op, 8'($urandom)};
         end
         rst_off();
         n = $urandom_range(60, 400);
`ifdef STEP_EN
         for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #2 step = ($urandom_range(0, 3) != 0);
         end
         step = 1'b1;
`else
         cycles(n);
`endif
      end

      cycles(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
